// File: rtl/imul_mul_rr_arbiter.sv
// imul_mul_rr_arbiter
//
// Shares one downstream 32-bit multiplier among NREQ requesters. Arbitration
// is round-robin. The multiplier registers its inputs and returns one result
// per issue, exactly one cycle later, with no backpressure. Each requester owns
// a one-entry response buffer, so a stalled consumer only blocks itself.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_val / req_rdy     per-requester request handshake (req_rdy one-hot or 0)
//   req_a / req_b         packed operands, requester i at [32*i +: 32]
//   resp_val / resp_rdy   per-requester response handshake
//   resp_data             packed products, requester i at [32*i +: 32]
//   mul_in_val            issue strobe to the multiplier
//   mul_in0 / mul_in1     multiplier operands (zero when not issuing)
//   mul_out_val / mul_out multiplier result, valid one cycle after issue

module imul_mul_rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_val,
    output logic [NREQ-1:0]    req_rdy,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    output logic [NREQ-1:0]    resp_val,
    input  logic [NREQ-1:0]    resp_rdy,
    output logic [NREQ*32-1:0] resp_data,
    output logic               mul_in_val,
    output logic [31:0]        mul_in0,
    output logic [31:0]        mul_in1,
    input  logic               mul_out_val,
    input  logic [31:0]        mul_out
);

    localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StFull = 2'd2
    } slot_e;

    // Per-requester slot state and response buffer
    slot_e       slot_q [NREQ];
    slot_e       slot_d [NREQ];
    logic [31:0] buf_q  [NREQ];
    logic [31:0] buf_d  [NREQ];

    // Round-robin pointer: first requester examined in the next search
    logic [PTRW-1:0] ptr_q, ptr_d;

    // One-stage tag pipeline tracking which slot the in-flight product belongs to
    logic [PTRW-1:0] tag_id_q, tag_id_d;
    logic            tag_val_q, tag_val_d;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic            grant_any;
    logic [PTRW-1:0] grant_idx;
    logic            capture;

    // ------------------------------------------------------------------
    // Eligibility: a slot still draining this cycle is not IDLE yet, so a
    // drained requester only becomes eligible the cycle after the drain.
    // Reset suppresses every grant.
    // ------------------------------------------------------------------
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_val[i] && (slot_q[i] == StIdle) && !reset;
        end
    end

    // ------------------------------------------------------------------
    // Rotating priority search starting at ptr_q, wrapping NREQ-1 -> 0.
    // ------------------------------------------------------------------
    always_comb begin : p_grant
        int unsigned cand;
        cand      = 0;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!grant_any && eligible[PTRW'(cand)]) begin
                grant[PTRW'(cand)] = 1'b1;
                grant_any          = 1'b1;
                grant_idx          = PTRW'(cand);
            end
        end
    end

    assign req_rdy = grant;

    // Pointer moves just past the winner; holds when nobody is granted
    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            if (grant_idx == PTRW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + PTRW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue: AND-OR mux on the one-hot grant, so operands are zero when idle
    // ------------------------------------------------------------------
    always_comb begin
        mul_in_val = grant_any;
        mul_in0    = '0;
        mul_in1    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                mul_in0 = mul_in0 | req_a[32*i +: 32];
                mul_in1 = mul_in1 | req_b[32*i +: 32];
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline: one stage, matching the multiplier latency
    // ------------------------------------------------------------------
    always_comb begin
        tag_val_d = grant_any;
        tag_id_d  = grant_any ? grant_idx : tag_id_q;
    end

    // A result strobe with no matching tag is stray and dropped
    assign capture = tag_val_q && mul_out_val;

    // ------------------------------------------------------------------
    // Slot FSMs: IDLE -grant-> BUSY -capture-> FULL -drain-> IDLE
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            slot_d[i] = slot_q[i];
            buf_d[i]  = buf_q[i];
            unique case (slot_q[i])
                StIdle: begin
                    if (grant[i]) begin
                        slot_d[i] = StBusy;
                    end
                end
                StBusy: begin
                    if (capture && (tag_id_q == PTRW'(i))) begin
                        slot_d[i] = StFull;
                        buf_d[i]  = mul_out;
                    end
                end
                StFull: begin
                    if (resp_rdy[i]) begin
                        slot_d[i] = StIdle;
                    end
                end
                default: begin
                    slot_d[i] = StIdle;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            resp_val[i]          = (slot_q[i] == StFull);
            resp_data[32*i +: 32] = buf_q[i];
        end
    end

    // ------------------------------------------------------------------
    // State registers; reset wins over any grant, capture or drain
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= '0;
            tag_id_q  <= '0;
            tag_val_q <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                slot_q[i] <= StIdle;
                buf_q[i]  <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            tag_id_q  <= tag_id_d;
            tag_val_q <= tag_val_d;
            for (int i = 0; i < NREQ; i++) begin
                slot_q[i] <= slot_d[i];
                buf_q[i]  <= buf_d[i];
            end
        end
    end

endmodule

// File: tb/tb_imul_mul_rr_arbiter.sv
// Bench for imul_mul_rr_arbiter: directed scenarios with literal expectations
// plus a per-cycle reference model of the arbiter's externally visible rules.

module tb_imul_mul_rr_arbiter;

    localparam int NREQ = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [NREQ-1:0]    req_val = '0;
    logic [NREQ-1:0]    req_rdy;
    logic [NREQ*32-1:0] req_a = '0;
    logic [NREQ*32-1:0] req_b = '0;
    logic [NREQ-1:0]    resp_val;
    logic [NREQ-1:0]    resp_rdy = '1;
    logic [NREQ*32-1:0] resp_data;
    logic               mul_in_val;
    logic [31:0]        mul_in0;
    logic [31:0]        mul_in1;
    logic               mul_out_val;
    logic [31:0]        mul_out;

    logic               mv_q = 1'b0;
    logic [31:0]        mo_q = '0;
    logic               spur = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    imul_mul_rr_arbiter #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy),
        .resp_data   (resp_data),
        .mul_in_val  (mul_in_val),
        .mul_in0     (mul_in0),
        .mul_in1     (mul_in1),
        .mul_out_val (mul_out_val),
        .mul_out     (mul_out)
    );

    // Downstream multiplier: registered inputs, one-cycle latency; spur injects
    // stray valid strobes that the arbiter must ignore.
    always @(posedge clk) begin
        if (reset) begin
            mv_q <= 1'b0;
            mo_q <= '0;
        end else begin
            mv_q <= mul_in_val;
            mo_q <= mul_in0 * mul_in1;
        end
    end
    assign mul_out_val = mv_q | spur;
    assign mul_out     = mo_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: outstanding op per requester with the cycle its
    // response becomes visible, and the round-robin pointer.
    // ------------------------------------------------------------------
    bit          m_init = 1'b0;
    int          m_ptr  = 0;
    int          cyc    = 0;
    bit          m_has  [NREQ];
    int          m_due  [NREQ];
    logic [31:0] m_prod [NREQ];

    always @(negedge clk) begin : compare
        int              win;
        int              idx;
        logic [NREQ-1:0] exp_rdy;
        logic [31:0]     e0, e1;
        bit              rv [NREQ];
        win     = -1;
        exp_rdy = '0;
        e0      = '0;
        e1      = '0;
        if (!reset) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (win < 0 && req_val[idx] && !m_has[idx]) win = idx;
            end
        end
        if (win >= 0) begin
            exp_rdy[win] = 1'b1;
            e0 = req_a[win*32 +: 32];
            e1 = req_b[win*32 +: 32];
        end
        check("req_rdy", 32'(req_rdy), 32'(exp_rdy));
        check("mul_in_val", 32'(mul_in_val), 32'(win >= 0));
        check("mul_in0", mul_in0, e0);
        check("mul_in1", mul_in1, e1);
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = m_has[i] && (cyc >= m_due[i]);
            if (m_init) begin
                check($sformatf("resp_val[%0d]", i), 32'(resp_val[i]), 32'(rv[i]));
                if (rv[i]) check($sformatf("resp_data[%0d]", i), resp_data[i*32 +: 32], m_prod[i]);
            end
        end
        if (reset) begin
            m_init = 1'b1;
            m_ptr  = 0;
            for (int i = 0; i < NREQ; i++) m_has[i] = 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++) if (rv[i] && resp_rdy[i]) m_has[i] = 1'b0;
            if (win >= 0) begin
                m_has[win]  = 1'b1;
                m_due[win]  = cyc + 2;
                m_prod[win] = e0 * e1;
                m_ptr       = (win + 1) % NREQ;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input int i, input logic [31:0] exp, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!resp_val[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " valid"}, 32'(resp_val[i]), 32'd1);
        check(name, resp_data[i*32 +: 32], exp);
    endtask

    logic [NREQ-1:0] rr_exp [5];
    int              g;
    bit              found;

    initial begin
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

        // Reset state; requests presented during reset must not be granted
        req_val = '1;
        tick();
        @(negedge clk);
        check("reset resp_val", 32'(resp_val), 32'd0);
        check("reset req_rdy", 32'(req_rdy), 32'd0);
        check("reset mul_in_val", 32'(mul_in_val), 32'd0);
        check("reset resp_data", resp_data[31:0] | resp_data[127:96], 32'd0);

        // Single op: 6*7
        tick();
        reset = 1'b0;
        req_val = 4'b0001;
        req_a[31:0] = 32'd6;
        req_b[31:0] = 32'd7;
        @(negedge clk);
        check("single req_rdy", 32'(req_rdy), 32'd1);
        check("single mul_in_val", 32'(mul_in_val), 32'd1);
        tick();
        req_val = '0;
        @(negedge clk);
        check("single t+1 resp_val", 32'(resp_val[0]), 32'd0);
        tick();
        @(negedge clk);
        check("single t+2 resp_val", 32'(resp_val[0]), 32'd1);
        check("single product", resp_data[31:0], 32'd42);

        // Round-robin from reset
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_val = '1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32] = 32'(i + 3);
            req_b[i*32 +: 32] = 32'd100;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("rr grant c%0d", c), 32'(req_rdy), 32'(rr_exp[c]));
            if (c == 4) begin
                check("rr c4 resp_val", 32'(resp_val), 32'b0100);
                check("rr c4 product", resp_data[95:64], 32'd500);
            end
            tick();
        end
        req_val = '0;
        repeat (4) tick();

        // Wrap and overflow, responses held with resp_rdy low
        resp_rdy = '0;
        req_val = 4'b1010;
        req_a[63:32] = 32'h0001_0000; req_b[63:32] = 32'h0001_0000;
        req_a[127:96] = 32'hFFFF_FFFF; req_b[127:96] = 32'd2;
        tick();
        tick();
        req_val = '0;
        wait_resp(1, 32'h0000_0000, "wrap 2^32");
        wait_resp(3, 32'hFFFF_FFFE, "wrap max*2");
        tick();
        resp_rdy = '1;
        tick();

        // Backpressure on requester 1
        resp_rdy = 4'b1101;
        req_val = '1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32] = 32'(i + 20);
            req_b[i*32 +: 32] = 32'd3;
        end
        wait_resp(1, 32'd63, "bp first");
        g = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            @(negedge clk);
            check("bp hold val", 32'(resp_val[1]), 32'd1);
            check("bp hold data", resp_data[63:32], 32'd63);
            check("bp no grant 1", 32'(req_rdy[1]), 32'd0);
            if (req_rdy != '0) g++;
        end
        check("bp others progress", 32'(g >= 9), 32'd1);
        tick();
        resp_rdy = '1;
        @(negedge clk);
        check("bp drain val", 32'(resp_val[1]), 32'd1);
        found = 1'b0;
        for (int c = 0; c < NREQ && !found; c++) begin
            tick();
            @(negedge clk);
            if (req_rdy[1]) found = 1'b1;
        end
        check("bp regrant", 32'(found), 32'd1);
        tick();
        req_val = '0;
        repeat (4) tick();

        // Reset in the cycle after a grant discards the op
        req_val = 4'b0100;
        req_a[95:64] = 32'd3;
        req_b[95:64] = 32'd5;
        @(negedge clk);
        check("midrst grant", 32'(req_rdy), 32'b0100);
        tick();
        reset = 1'b1;
        req_val = '0;
        @(negedge clk);
        check("midrst t+1", 32'(resp_val), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("midrst t+2", 32'(resp_val), 32'd0);
        tick();
        @(negedge clk);
        check("midrst t+3", 32'(resp_val), 32'd0);
        tick();
        req_val = 4'b0100;
        req_a[95:64] = 32'd9;
        req_b[95:64] = 32'd9;
        tick();
        req_val = '0;
        resp_rdy = '0;
        wait_resp(2, 32'd81, "post-reset op");
        tick();
        resp_rdy = '1;

        // Random soak; the compare process scores every cycle
        for (int c = 0; c < 10000; c++) begin
            tick();
            req_val = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                resp_rdy[i] = ($urandom_range(0, 3) != 0);
                req_a[i*32 +: 32] = $urandom;
                req_b[i*32 +: 32] = $urandom;
            end
            spur  = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 999) == 0);
        end
        tick();
        reset = 1'b0;
        spur = 1'b0;
        req_val = '0;
        resp_rdy = '1;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
